ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. Sends one command byte to the attached mouse or keyboard, e.g. 0xF4 (enable data reporting) or 0xFF (reset).
- Sits beside mouse_decoder and keyboard_decoder in the peripheral handler, sharing the PS2_CLK/PS2_DAT pins.
- Pins are open-drain: the top level drives a line low when the matching *_oe is 1, otherwise releases it to high-Z.
- tx_busy tells the decoders to ignore bus activity during a transmission.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_sync_edge.sv | 28 ++
 rtl/ps2_host_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame size and default bus timing.
// The host transmitter, mouse_decoder and keyboard_decoder all import this package.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 10;
    localparam int PS2_CNT_W      = 20;

    localparam int PS2_INHIBIT_CYCLES = 6000;
    localparam int PS2_SETUP_CYCLES   = 250;
    localparam int PS2_START_TIMEOUT  = 750000;
    localparam int PS2_XFER_TIMEOUT   = 100000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_WAIT_FIRST,
        ST_DATA,
        ST_WAIT_ACK,
        ST_WAIT_IDLE,
        ST_ERR
    } ps2_state_e;

    // Host frame after the start bit: stop, odd parity, data. Bit 0 goes out first.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 line plus a registered falling-edge strobe.
// Registers reset to 1, which is the idle bus level, so releasing reset never fakes an edge.
module ps2_sync_edge (
    input  logic CLOCK50,
    input  logic reset,
    input  logic line_raw,
    output logic line_s,
    output logic fall
);

    logic line_meta;
    logic line_prev;

    always_ff @(posedge CLOCK50) begin
        if (reset) begin
            line_meta <= 1'b1;
            line_s    <= 1'b1;
            line_prev <= 1'b1;
            fall      <= 1'b0;
        end else begin
            line_meta <= line_raw;
            line_s    <= line_meta;
            line_prev <= line_s;
            fall      <= line_prev & ~line_s;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over the open-drain
// PS2_CLK/PS2_DAT pins and reports ACK (tx_done) or timeout/NACK (tx_error).
//
//   state         | meaning
//   ST_IDLE       | bus released, waiting for a command
//   ST_INHIBIT    | clock held low to abort any device traffic
//   ST_REQ        | data pulled low (start bit) with clock still low
//   ST_WAIT_FIRST | clock released, waiting for the device's first falling edge
//   ST_DATA       | presenting data, parity and stop on successive falls
//   ST_WAIT_ACK   | bus released, sampling the device ACK on the next fall
//   ST_WAIT_IDLE  | waiting for both lines to return high
//   ST_ERR        | one-cycle error report
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int SETUP_CYCLES   = PS2_SETUP_CYCLES,
    parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
    parameter int XFER_TIMEOUT   = PS2_XFER_TIMEOUT
) (
    input  logic       CLOCK50,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam logic [PS2_CNT_W-1:0] INHIBIT_LOAD = PS2_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [PS2_CNT_W-1:0] SETUP_LOAD   = PS2_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [PS2_CNT_W-1:0] START_LOAD   = PS2_CNT_W'(START_TIMEOUT - 1);
    localparam logic [PS2_CNT_W-1:0] XFER_LOAD    = PS2_CNT_W'(XFER_TIMEOUT - 1);

    ps2_state_e                  state;
    logic [PS2_FRAME_BITS-1:0]   shreg;
    logic [3:0]                  bit_cnt;
    logic [PS2_CNT_W-1:0]        tmr;
    logic [PS2_CNT_W-1:0]        xfer_tmr;

    logic clk_s;
    logic clk_fall;
    logic dat_meta;
    logic dat_s;

    ps2_sync_edge u_clk_sync (
        .CLOCK50  (CLOCK50),
        .reset    (reset),
        .line_raw (ps2_clk_in),
        .line_s   (clk_s),
        .fall     (clk_fall)
    );

    always_ff @(posedge CLOCK50) begin
        if (reset) begin
            dat_meta <= 1'b1;
            dat_s    <= 1'b1;
        end else begin
            dat_meta <= ps2_dat_in;
            dat_s    <= dat_meta;
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign tx_busy   = (state != ST_IDLE);

    always_ff @(posedge CLOCK50) begin
        if (reset) begin
            state      <= ST_IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            tmr        <= '0;
            xfer_tmr   <= '0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            // Both timers are saturating down-counters; a state reloads its own on entry.
            if (tmr != '0)      tmr      <= tmr - 1'b1;
            if (xfer_tmr != '0) xfer_tmr <= xfer_tmr - 1'b1;

            case (state)
                ST_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (cmd_valid) begin
                        shreg      <= ps2_frame(cmd_data);
                        bit_cnt    <= '0;
                        tmr        <= INHIBIT_LOAD;
                        ps2_clk_oe <= 1'b1;
                        state      <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (tmr == '0) begin
                        ps2_dat_oe <= 1'b1;
                        tmr        <= SETUP_LOAD;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tmr == '0) begin
                        ps2_clk_oe <= 1'b0;
                        tmr        <= START_LOAD;
                        state      <= ST_WAIT_FIRST;
                    end
                end
                ST_WAIT_FIRST: begin
                    if (clk_fall) begin
                        ps2_dat_oe <= ~shreg[0];
                        shreg      <= {1'b0, shreg[PS2_FRAME_BITS-1:1]};
                        bit_cnt    <= 4'd1;
                        xfer_tmr   <= XFER_LOAD;
                        state      <= ST_DATA;
                    end else if (tmr == '0) begin
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        state      <= ST_ERR;
                    end
                end
                ST_DATA: begin
                    if (xfer_tmr == '0) begin
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        state      <= ST_ERR;
                    end else if (clk_fall) begin
                        ps2_dat_oe <= ~shreg[0];
                        shreg      <= {1'b0, shreg[PS2_FRAME_BITS-1:1]};
                        bit_cnt    <= bit_cnt + 1'b1;
                        // Fall #10 puts out the stop bit (a released line) and ends the frame.
                        if (bit_cnt == 4'(PS2_FRAME_BITS - 1)) state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (xfer_tmr == '0) begin
                        tx_error <= 1'b1;
                        state    <= ST_ERR;
                    end else if (clk_fall) begin
                        if (dat_s) begin
                            tx_error <= 1'b1;
                            state    <= ST_ERR;
                        end else begin
                            state <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (xfer_tmr == '0) begin
                        tx_error <= 1'b1;
                        state    <= ST_ERR;
                    end else if (clk_s && dat_s) begin
                        tx_done <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
